rocc_resp_writer: RTL and testbench

Response-side end of the RoCC accelerator interface: returns results to the core for commands accepted by the command decoder. It queues a destination-register tag per accepted command, accepts 32-bit results from the operation units over the strobe/BUSY handshake, and drives the RoCC response channel with valid/ready. It also produces the accelerator-busy indication from outstanding commands.

---
 rtl/rocc_pkg.sv | 22 ++
 rtl/rocc_tag_fifo.sv | 46 ++++
 rtl/rocc_resp_writer.sv | 85 ++++++++
 tb/tb_rocc_resp_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_pkg.sv
// Shared RoCC types: response FSM, decoder FSM and tag bundle.
package rocc_pkg;

  localparam int RD_WIDTH = 5;

  typedef enum logic {
    IDLE,
    RESP
  } resp_state_t;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_ISSUE,
    CMD_WAIT
  } cmd_state_t;

  typedef struct packed {
    logic [RD_WIDTH-1:0] rd;
    logic                xd;
  } rocc_tag_t;

endpackage

// File: rtl/rocc_tag_fifo.sv
// Outstanding-command tag queue; head is the oldest tag.
module rocc_tag_fifo
  import rocc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rocc_tag_t     din,
  input  logic          pop,
  output rocc_tag_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  rocc_tag_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/rocc_resp_writer.sv
// RoCC response path: tag queue, result capture and response handshake.
module rocc_resp_writer
  import rocc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RES_WIDTH  = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tag_valid,
  output logic                  tag_ready,
  input  logic [RD_WIDTH-1:0]   tag_rd,
  input  logic                  tag_xd,
  input  logic [RES_WIDTH-1:0]  result_data,
  input  logic                  result_STB,
  output logic                  result_BUSY,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RD_WIDTH-1:0]   resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  acc_busy
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;

  resp_state_t   state;
  rocc_tag_t     head;
  rocc_tag_t     din;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          accept;

  assign din    = '{rd: tag_rd, xd: tag_xd};
  assign push   = tag_valid && !full;
  assign accept = result_STB && !result_BUSY;
  // Tag leaves the queue on a dropped result or a completed handshake.
  assign pop    = (accept && !head.xd)
               || (state == RESP && resp_ready);

  assign tag_ready   = !full;
  assign result_BUSY = empty || (state != IDLE);
  assign resp_valid  = (state == RESP);
  assign acc_busy    = (count != '0) || (state == RESP);

  rocc_tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (din),
    .pop  (pop),
    .head (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      resp_rd   <= '0;
      resp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && head.xd) begin
            state     <= RESP;
            resp_rd   <= head.rd;
            resp_data <= DATA_WIDTH'(result_data);
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rocc_resp_writer.sv
// Randomized and directed bench for rocc_resp_writer against a queue model.
module tb_rocc_resp_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tv = 1'b0;
  logic        tag_ready;
  logic [4:0]  trd = '0;
  logic        txd = 1'b0;
  logic [31:0] rdat = '0;
  logic        stb = 1'b0;
  logic        result_BUSY;
  logic        resp_valid;
  logic        rrdy = 1'b0;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        acc_busy;

  int total = 0;
  int bad   = 0;

  bit [5:0]  tq[$];
  bit        pend;
  bit [4:0]  prd;
  bit [63:0] pdata;
  bit        fresh;
  bit [4:0]  dut_log[$];

  always #5 clk = ~clk;

  rocc_resp_writer dut (
    .clk        (clk),
    .rst        (rst),
    .tag_valid  (tv),
    .tag_ready  (tag_ready),
    .tag_rd     (trd),
    .tag_xd     (txd),
    .result_data(rdat),
    .result_STB (stb),
    .result_BUSY(result_BUSY),
    .resp_valid (resp_valid),
    .resp_ready (rrdy),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .acc_busy   (acc_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete();
    pend  = 0;
    prd   = '0;
    pdata = '0;
    fresh = 1;
  endtask

  task automatic check_outs();
    chk("resp_valid", resp_valid, pend);
    chk("acc_busy", acc_busy, (tq.size() != 0) || pend);
    chk("tag_ready", tag_ready, tq.size() < 4);
    chk("result_BUSY", result_BUSY, (tq.size() == 0) || pend);
    if (pend || fresh) begin
      chk("resp_rd", resp_rd, prd);
      chk("resp_data", resp_data, pdata);
    end
  endtask

  // Check this cycle, apply the model's rules, then advance one clock.
  task automatic tick();
    bit do_push, do_acc, do_hs;
    check_outs();
    if (resp_valid && rrdy) dut_log.push_back(resp_rd);
    do_push = tv && (tq.size() < 4);
    do_acc  = stb && (tq.size() != 0) && !pend;
    do_hs   = pend && rrdy;
    if (do_acc) begin
      if (tq[0][0]) begin
        pend  = 1;
        prd   = tq[0][5:1];
        pdata = 64'(rdat);
        fresh = 0;
      end else begin
        void'(tq.pop_front());
      end
    end
    if (do_hs) begin
      void'(tq.pop_front());
      pend = 0;
    end
    if (do_push) tq.push_back({trd, txd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    tv   = 0;
    stb  = 0;
    rrdy = 0;
  endtask

  initial begin
    model_reset();
    #3 rst = 0;
    #1;
    chk("rst valid", resp_valid, 0);
    chk("rst busy", acc_busy, 0);
    chk("rst ready", tag_ready, 1);
    chk("rst BUSY", result_BUSY, 1);
    chk("rst data", resp_data, 0);
    @(posedge clk);
    #1 rst = 1;

    // Basic push/result/response
    tv = 1; trd = 5; txd = 1;
    tick();
    tv = 0; stb = 1; rdat = 32'hDEADBEEF;
    tick();
    stb = 0;
    chk("t1 valid", resp_valid, 1);
    chk("t1 rd", resp_rd, 5);
    chk("t1 data", resp_data, 64'h00000000DEADBEEF);
    stb = 1; rdat = 32'h12345678;
    repeat (10) tick();
    chk("hold data", resp_data, 64'h00000000DEADBEEF);
    stb = 0; rrdy = 1;
    tick();
    rrdy = 0;
    tick();
    chk("t1 done busy", acc_busy, 0);

    // Fill queue, refuse fifth, three responses out of four
    for (int i = 0; i < 4; i++) begin
      tv = 1; trd = 5'(i + 1); txd = (i != 1);
      tick();
    end
    chk("full ready", tag_ready, 0);
    trd = 9; txd = 1;
    tick();
    tv = 0;
    dut_log.delete();
    stb = 1; rrdy = 1;
    for (int i = 0; i < 10; i++) begin
      rdat = $urandom;
      tick();
    end
    idle_in();
    chk("resp count", dut_log.size(), 3);
    while (dut_log.size() < 3) dut_log.push_back(5'd31);
    chk("resp0 rd", dut_log[0], 1);
    chk("resp1 rd", dut_log[1], 3);
    chk("resp2 rd", dut_log[2], 4);

    // STB on empty queue is held until a tag arrives
    stb = 1; rdat = 32'hCAFE0001;
    tick();
    tick();
    tv = 1; trd = 7; txd = 1;
    tick();
    tv = 0;
    tick();
    stb = 0;
    chk("held valid", resp_valid, 1);
    chk("held rd", resp_rd, 7);
    chk("held data", resp_data, 64'hCAFE0001);

    // Async reset mid-RESP with three tags queued
    for (int i = 0; i < 2; i++) begin
      tv = 1; trd = 5'(20 + i); txd = 1;
      tick();
    end
    tv = 0;
    chk("pre-rst q3 valid", resp_valid, 1);
    #2 rst = 0;
    #1;
    chk("mid rst valid", resp_valid, 0);
    chk("mid rst busy", acc_busy, 0);
    chk("mid rst ready", tag_ready, 1);
    chk("mid rst BUSY", result_BUSY, 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    tick();
    tv = 1; trd = 12; txd = 1;
    tick();
    tv = 0; stb = 1; rdat = 32'h0BADF00D;
    tick();
    stb = 0; rrdy = 1;
    chk("post rst rd", resp_rd, 12);
    chk("post rst data", resp_data, 64'h0BADF00D);
    tick();
    idle_in();
    tick();

    // Push and pop together with two queued across several wraps
    for (int i = 0; i < 2; i++) begin
      tv = 1; trd = 5'(10 + i); txd = 0;
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      tv = 1; trd = 5'(16 + i); txd = (i >= 10);
      stb = 1; rdat = $urandom;
      tick();
      chk("wrap ready", tag_ready, 1);
    end
    tv = 0; rrdy = 1;
    dut_log.delete();
    repeat (6) tick();
    idle_in();
    chk("wrap count", dut_log.size(), 2);
    while (dut_log.size() < 2) dut_log.push_back(5'd0);
    chk("wrap rd0", dut_log[0], 26);
    chk("wrap rd1", dut_log[1], 27);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      tv   = ($urandom_range(0, 2) == 0);
      trd  = 5'($urandom);
      txd  = 1'($urandom);
      stb  = ($urandom_range(0, 1) == 0);
      rdat = $urandom;
      rrdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
